instance_pool_arbiter: RTL



---
 rtl/instance_pool_pkg.sv | 19 +
 rtl/instance_pool_arbiter_rr.sv | 35 +++
 rtl/instance_pool_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/instance_pool_pkg.sv
// Shared types and width helpers for the instance pool arbiter and its round-robin arbiter.
package instance_pool_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } pool_state_e;

  // Index width that stays at least 1 bit so single-entry pools still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/instance_pool_arbiter_rr.sv
// Round-robin N-way arbiter: scans upward from ptr_i (mod N), returns a one-hot grant and its index.
module rr_arbiter
  import instance_pool_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] pos;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr_i) + k) % N);
      if (!found && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
        found      = 1'b1;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/instance_pool_arbiter.sv
// Shares NUM_SLOTS instance handles among NUM_REQ requesters; records each slot's type and supports drain.
module instance_pool_arbiter
  import instance_pool_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_SLOTS = 16,
  parameter int TYPE_W    = 4,
  localparam int REQ_W    = idx_w(NUM_REQ),
  localparam int SLOT_W   = idx_w(NUM_SLOTS),
  localparam int CNT_W    = cnt_w(NUM_SLOTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*TYPE_W-1:0]   req_type_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic                        grant_valid_o,
  output logic [REQ_W-1:0]            grant_req_id_o,
  output logic [SLOT_W-1:0]           grant_slot_o,
  output logic [TYPE_W-1:0]           grant_type_o,
  input  logic                        free_valid_i,
  input  logic [SLOT_W-1:0]           free_slot_i,
  input  logic [SLOT_W-1:0]           lookup_slot_i,
  output logic [TYPE_W-1:0]           lookup_type_o,
  output logic                        lookup_live_o,
  output logic [CNT_W-1:0]            in_use_o,
  output logic                        pool_full_o,
  output logic                        err_double_free_o,
  input  logic                        drain_req_i,
  output logic                        drain_done_o,
  output pool_state_e                 state_o
);

  logic [NUM_SLOTS-1:0] bitmap_q, bitmap_d;
  logic [TYPE_W-1:0]    type_q [NUM_SLOTS];
  logic [REQ_W-1:0]     rr_ptr_q, win_idx;
  logic [NUM_REQ-1:0]   win_gnt;
  logic                 win_any;
  logic [SLOT_W-1:0]    free_idx;
  logic [TYPE_W-1:0]    win_type;
  logic                 alloc_en, alloc_fire, free_ok;
  logic [CNT_W-1:0]     in_use_q, in_use_d;
  logic                 grant_valid_q, err_q, drain_done_q;
  logic [REQ_W-1:0]     grant_req_id_q;
  logic [SLOT_W-1:0]    grant_slot_q;
  logic [TYPE_W-1:0]    grant_type_q;
  pool_state_e          state_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Lowest free slot of the registered bitmap; a slot freed this cycle is not yet visible.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!bitmap_q[i]) free_idx = SLOT_W'(i);
    end
  end

  assign alloc_en    = (state_q == RUN) && !(&bitmap_q);
  assign req_ready_o = alloc_en ? win_gnt : '0;
  assign alloc_fire  = alloc_en && win_any;
  assign win_type    = req_type_i[win_idx*TYPE_W +: TYPE_W];
  assign free_ok     = free_valid_i && bitmap_q[free_slot_i];

  always_comb begin
    bitmap_d = bitmap_q;
    if (alloc_fire) bitmap_d[free_idx] = 1'b1;
    if (free_ok)    bitmap_d[free_slot_i] = 1'b0;
    case ({alloc_fire, free_ok})
      2'b10:   in_use_d = in_use_q + CNT_W'(1);
      2'b01:   in_use_d = in_use_q - CNT_W'(1);
      default: in_use_d = in_use_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q       <= '0;
      rr_ptr_q       <= '0;
      in_use_q       <= '0;
      grant_valid_q  <= 1'b0;
      grant_req_id_q <= '0;
      grant_slot_q   <= '0;
      grant_type_q   <= '0;
      err_q          <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) type_q[i] <= '0;
    end else begin
      bitmap_q      <= bitmap_d;
      in_use_q      <= in_use_d;
      grant_valid_q <= alloc_fire;
      err_q         <= free_valid_i && !bitmap_q[free_slot_i];
      if (alloc_fire) begin
        type_q[free_idx] <= win_type;
        rr_ptr_q         <= (win_idx == REQ_W'(NUM_REQ - 1)) ? '0 : win_idx + REQ_W'(1);
        grant_req_id_q   <= win_idx;
        grant_slot_q     <= free_idx;
        grant_type_q     <= win_type;
      end
    end
  end

  // Drain FSM; drain_done is registered alongside the state it mirrors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      drain_done_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: if (drain_req_i) state_q <= DRAIN;
        DRAIN: begin
          if (!drain_req_i) begin
            state_q <= RUN;
          end else if (in_use_q == '0) begin
            state_q      <= DRAINED;
            drain_done_q <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain_req_i) begin
            state_q      <= RUN;
            drain_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= RUN;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid_o     = grant_valid_q;
  assign grant_req_id_o    = grant_req_id_q;
  assign grant_slot_o      = grant_slot_q;
  assign grant_type_o      = grant_type_q;
  assign lookup_type_o     = type_q[lookup_slot_i];
  assign lookup_live_o     = bitmap_q[lookup_slot_i];
  assign in_use_o          = in_use_q;
  assign pool_full_o       = (in_use_q == CNT_W'(NUM_SLOTS));
  assign err_double_free_o = err_q;
  assign drain_done_o      = drain_done_q;
  assign state_o           = state_q;

endmodule
